wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin Wishbone arbiter that shares the single core-side bus between N bus masters, e.g. the CPU core plus a DMA or debug master. It sits between the masters and `wb_interconnect`. It grants one master at a time for the whole duration of that master's `cyc`. A bus watchdog terminates any transfer the addressed slave never acknowledges.

## Interface
- `N`, default 2: number of masters, ≥1.
- `TimeoutCycles`, default 64: stalled-strobe cycles before abort. 0 disables the watchdog.
- `clk_in`, in, 1: system clock. All state changes on the rising edge.
- `reset_in`, in, 1: synchronous, active-high reset.
- `bus_in`, `wb_bus` slave modport array [N]: master-side ports. Index 0 is the CPU core.
- `bus_out`, `wb_bus` master modport, 1: to the interconnect.
- `grant_o`, out, max(1,$clog2(N)): index of the current or last granted master.
- `busy_o`, out, 1: high in GRANT and ABORT.
- `timeout_o`, out, 1: one-cycle pulse when the watchdog fires.

## Operation
- Fields used: `cyc`, `stb`, `we`, `sel`, `adr`, data in both directions, `ack`, `err`.
- States:
  - IDLE: `bus_out.cyc`/`stb` = 0. If any `bus_in[i].cyc` = 1, select a winner, register it into `grant_o`, go to GRANT.
  - GRANT: `cyc`, `stb`, `we`, `sel`, `adr` and write data of master `grant_o` route combinationally to `bus_out`. `bus_out` `ack`/`err` route only to that master. All other masters see `ack` = `err` = 0. Read data is broadcast to all masters.
    - Granted master drops `cyc` → IDLE.
    - Watchdog fires → ABORT.
  - ABORT: `bus_out.cyc`/`stb` = 0. Stay until the granted master drops `cyc`, then IDLE.
- Round-robin selection:
  - The search starts at `(last_grant + 1) mod N` and wraps. The first index with `cyc` = 1 wins.
  - `last_grant` updates on each grant.
  - Reset sets `last_grant` = N−1, so master 0 has first priority.
  - N = 1: always master 0.
- Grant is held until `cyc` falls. Multi-beat and RMW cycles are never split. No preemption.
- Watchdog:
  - The counter resets on entering GRANT and on every cycle in which `bus_out.ack` or `bus_out.err` = 1.
  - It increments each GRANT cycle in which `bus_out.stb` = 1 with no `ack`/`err`.
  - When the count reaches `TimeoutCycles` in GRANT:
    - The arbiter drives `err` = 1 to the granted master combinationally for exactly that cycle.
    - `bus_out.cyc`/`stb` are forced to 0 in that same cycle.
    - `timeout_o` pulses for that cycle.
    - Next state is ABORT.
- A late slave `ack` arriving in ABORT or IDLE is dropped and not routed.
- Reset mid-transfer: next cycle is IDLE, `bus_out.cyc` = 0, and no `ack`/`err` reaches any master.

## Timing
- Reset values:
  - State IDLE, `grant_o` = N−1.
  - `busy_o` = 0, `timeout_o` = 0, counter = 0.
  - All `bus_out` control outputs = 0, all master `ack`/`err` = 0.
- Arbitration latency: 1 cycle. Master `cyc` rising at edge k → `bus_out.cyc` = 1 in the cycle after edge k+1.
- Release: `cyc` falling drops `bus_out.cyc` in the same cycle (combinational route). The FSM is in IDLE after the next edge.
- Re-grant costs 1 dead IDLE cycle between back-to-back grants.
- `ack` and read data pass through combinationally. The arbiter adds no latency within a granted cycle.
- Requests arriving while in GRANT or ABORT wait. They are evaluated only in IDLE.
- Simultaneous requests are resolved only by round-robin order.

## Test plan
- Single master: master 0 performs a write to 0x100 with 0xDEADBEEF. Require:
  - `bus_out.cyc` one cycle after request.
  - Slave ack returns to master 0 only.
  - `grant_o` = 0, `busy_o` = 1 during the cycle, then 0.
- Contention, N=2: both masters hold `cyc` continuously for four 1-beat cycles each. Require:
  - Grants alternate 0,1,0,1.
  - One dead cycle between grants.
  - Master 1 never sees master 0's `ack`.
- Hold: master 1 holds `cyc` across 3 beats while master 0 requests. Require master 0 is granted only after master 1 drops `cyc`.
- Watchdog, `TimeoutCycles` = 8: the slave never acks. Require:
  - Exactly 8 stalled-stb cycles, then `err` + `timeout_o` for 1 cycle with `bus_out.cyc` = 0.
  - ABORT until the master drops `cyc`.
  - A late `ack` is not forwarded.
- Watchdog reset: the slave acks after 7 cycles on each of 3 beats with `TimeoutCycles` = 8. Require no timeout.
- Reset mid-transfer: assert `reset_in` during GRANT. Require:
  - `bus_out.cyc` = 0 after the edge and `grant_o` = N−1.
  - The next simultaneous request from all masters grants master 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one Wishbone bus between N masters.
//
// A master keeps the bus for as long as it holds cyc. A watchdog ends any
// transfer whose strobe stays unanswered for TimeoutCycles cycles. It answers
// the stalled master with err and then waits for that master to let go.
//
// Parameters:
//   N             number of masters (>= 1); index 0 is the CPU core
//   TimeoutCycles stalled-strobe cycles before abort, 0 disables the watchdog
//   AW / DW       address / data width (select width is DW/8)
//
// Ports:
//   clk_in, reset_in         clock, synchronous active-high reset
//   bus_in_*  [N]            master-side Wishbone ports (slave view)
//   bus_out_*                single interconnect-side Wishbone port
//   grant_o                  index of the current or last granted master
//   busy_o                   high while a master owns the bus or is being aborted
//   timeout_o                one-cycle pulse when the watchdog fires
module wb_arbiter #(
  parameter int N             = 2,
  parameter int TimeoutCycles = 64,
  parameter int AW            = 32,
  parameter int DW            = 32,
  localparam int SW           = DW / 8,
  localparam int GW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  // master side
  input  logic [N-1:0]           bus_in_cyc,
  input  logic [N-1:0]           bus_in_stb,
  input  logic [N-1:0]           bus_in_we,
  input  logic [N-1:0][SW-1:0]   bus_in_sel,
  input  logic [N-1:0][AW-1:0]   bus_in_adr,
  input  logic [N-1:0][DW-1:0]   bus_in_dat_w,
  output logic [N-1:0][DW-1:0]   bus_in_dat_r,
  output logic [N-1:0]           bus_in_ack,
  output logic [N-1:0]           bus_in_err,
  // interconnect side
  output logic                   bus_out_cyc,
  output logic                   bus_out_stb,
  output logic                   bus_out_we,
  output logic [SW-1:0]          bus_out_sel,
  output logic [AW-1:0]          bus_out_adr,
  output logic [DW-1:0]          bus_out_dat_w,
  input  logic [DW-1:0]          bus_out_dat_r,
  input  logic                   bus_out_ack,
  input  logic                   bus_out_err,
  // status
  output logic [GW-1:0]          grant_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_grant;
  logic          r_busy;
  logic [CW-1:0] r_cnt;

  logic          w_any;
  logic [GW-1:0] w_winner;
  int            w_idx;
  logic          w_granted;
  logic          w_timeout;
  logic          w_route;

  // Round-robin search: start one past the last grant and wrap; the first
  // requester found wins. Only evaluated while idle.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = int'(r_grant) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (!w_any && bus_in_cyc[GW'(w_idx)]) begin
        w_any    = 1'b1;
        w_winner = GW'(w_idx);
      end
    end
  end

  // Reset silences the bus in the same cycle it is asserted, so a transfer
  // interrupted by reset never leaks an ack or err to a master.
  assign w_granted = (r_state == S_GRANT) && !reset_in;

  generate
    if (TimeoutCycles == 0) begin : g_no_wdog
      assign w_timeout = 1'b0;
    end else begin : g_wdog
      assign w_timeout = w_granted && (r_cnt == CW'(TimeoutCycles));
    end
  endgenerate

  // The firing cycle already belongs to the abort: the bus is dropped and
  // any slave response in that cycle is discarded.
  assign w_route = w_granted && !w_timeout;

  assign bus_out_cyc   = w_route && bus_in_cyc[r_grant];
  assign bus_out_stb   = w_route && bus_in_stb[r_grant];
  assign bus_out_we    = w_route && bus_in_we[r_grant];
  assign bus_out_sel   = w_route ? bus_in_sel[r_grant] : '0;
  assign bus_out_adr   = bus_in_adr[r_grant];
  assign bus_out_dat_w = bus_in_dat_w[r_grant];

  for (genvar gi = 0; gi < N; gi++) begin : g_master
    assign bus_in_dat_r[gi] = bus_out_dat_r;
    assign bus_in_ack[gi]   = w_route && (r_grant == GW'(gi)) && bus_out_ack;
    assign bus_in_err[gi]   = (r_grant == GW'(gi)) &&
                              ((w_route && bus_out_err) || w_timeout);
  end

  assign grant_o   = r_grant;
  assign busy_o    = r_busy;
  assign timeout_o = w_timeout;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_grant <= GW'(N - 1);
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_state <= S_GRANT;
            r_grant <= w_winner;
            r_busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_timeout) begin
            r_state <= S_ABORT;
            r_cnt   <= '0;
          end else if (!bus_in_cyc[r_grant]) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (bus_out_ack || bus_out_err) begin
            r_cnt <= '0;
          end else if (bus_out_stb && (TimeoutCycles != 0)) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ABORT: begin
          // Hold the bus off until the aborted master gives up its cycle.
          if (!bus_in_cyc[r_grant]) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios followed by randomized traffic for
// wb_arbiter (N=2, TimeoutCycles=8), checked every cycle against a
// rule-level reference model.
module tb_wb_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         m_cyc, m_stb, m_we;
  logic [N-1:0][SW-1:0] m_sel;
  logic [N-1:0][AW-1:0] m_adr;
  logic [N-1:0][DW-1:0] m_dat_w;
  logic [N-1:0][DW-1:0] m_dat_r;
  logic [N-1:0]         m_ack, m_err;
  logic                 o_cyc, o_stb, o_we;
  logic [SW-1:0]        o_sel;
  logic [AW-1:0]        o_adr;
  logic [DW-1:0]        o_dat_w;
  logic [DW-1:0]        s_dat_r;
  logic                 sl_ack, sl_auto, s_err;
  logic                 s_ack;
  logic [0:0]           grant;
  logic                 busy, tmo;

  // Slave ack: either driven by the stimulus or answering every strobe at once.
  assign s_ack = sl_auto ? (o_cyc & o_stb) : sl_ack;

  wb_arbiter #(.N(N), .TimeoutCycles(TO), .AW(AW), .DW(DW)) dut (
    .clk_in(clk), .reset_in(rst),
    .bus_in_cyc(m_cyc), .bus_in_stb(m_stb), .bus_in_we(m_we),
    .bus_in_sel(m_sel), .bus_in_adr(m_adr), .bus_in_dat_w(m_dat_w),
    .bus_in_dat_r(m_dat_r), .bus_in_ack(m_ack), .bus_in_err(m_err),
    .bus_out_cyc(o_cyc), .bus_out_stb(o_stb), .bus_out_we(o_we),
    .bus_out_sel(o_sel), .bus_out_adr(o_adr), .bus_out_dat_w(o_dat_w),
    .bus_out_dat_r(s_dat_r), .bus_out_ack(s_ack), .bus_out_err(s_err),
    .grant_o(grant), .busy_o(busy), .timeout_o(tmo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference model: owner = master holding the bus (-1 none), aborted flag,
  // last granted index, consecutive unanswered strobe cycles.
  int md_owner, md_last, md_stall;
  bit md_abort;

  // values captured at the sampling point for the following clock edge
  bit           ex_fire, cap_ack, cap_err, cap_rst;
  logic [N-1:0] cap_cyc, cap_stb;

  // observations of the last sampled cycle
  logic [N-1:0] ob_ack, ob_err;
  logic         ob_cyc, ob_stb, ob_to, ob_busy;
  int           ob_grant;
  logic [AW-1:0] ob_adr;
  logic [DW-1:0] ob_dat_w;

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic check_cycle();
    bit live, fire;
    logic [N-1:0] e_ack, e_err;
    logic e_cyc, e_stb;
    @(negedge clk);
    live  = (md_owner >= 0) && !md_abort && !rst;
    fire  = live && (md_stall >= TO);
    e_ack = '0; e_err = '0; e_cyc = 1'b0; e_stb = 1'b0;
    if (live) begin
      if (!fire) begin
        e_cyc = m_cyc[md_owner];
        e_stb = m_stb[md_owner];
        e_ack[md_owner] = s_ack;
      end
      e_err[md_owner] = fire || s_err;
    end
    check_eq("grant", grant, md_last);
    check_eq("busy", busy, md_owner >= 0);
    check_eq("timeout", tmo, fire);
    check_eq("out_cyc", o_cyc, e_cyc);
    check_eq("out_stb", o_stb, e_stb);
    check_eq("ack", m_ack, e_ack);
    check_eq("err", m_err, e_err);
    if (e_cyc) begin
      check_eq("out_adr", o_adr, m_adr[md_owner]);
      check_eq("out_dat", o_dat_w, m_dat_w[md_owner]);
      check_eq("out_we", o_we, m_we[md_owner]);
      check_eq("out_sel", o_sel, m_sel[md_owner]);
    end
    for (int i = 0; i < N; i++) check_eq("dat_r", m_dat_r[i], s_dat_r);
    ex_fire = fire; cap_ack = s_ack; cap_err = s_err; cap_rst = rst;
    cap_cyc = m_cyc; cap_stb = m_stb;
    ob_ack = m_ack; ob_err = m_err; ob_cyc = o_cyc; ob_stb = o_stb; ob_to = tmo;
    ob_busy = busy; ob_grant = int'(grant); ob_adr = o_adr; ob_dat_w = o_dat_w;
  endtask

  task automatic edge_update();
    int w;
    @(posedge clk);
    if (cap_rst) begin
      md_owner = -1; md_abort = 0; md_last = N - 1; md_stall = 0;
    end else if (md_owner < 0) begin
      w = rr_pick(cap_cyc, md_last);
      if (w >= 0) begin
        md_owner = w; md_last = w; md_stall = 0;
      end
    end else if (!md_abort) begin
      if (ex_fire) md_abort = 1;
      else if (!cap_cyc[md_owner]) md_owner = -1;
      else if (cap_ack || cap_err) md_stall = 0;
      else if (cap_stb[md_owner]) md_stall++;
    end else if (!cap_cyc[md_owner]) begin
      md_owner = -1; md_abort = 0;
    end
    #1;
  endtask

  task automatic step();
    check_cycle();
    edge_update();
  endtask

  task automatic new_beat(input int i);
    m_we[i]    = 1'($urandom);
    m_sel[i]   = 4'($urandom);
    m_adr[i]   = $urandom;
    m_dat_w[i] = $urandom;
  endtask

  task automatic settle();
    m_cyc = '0; m_stb = '0; sl_ack = 0; s_err = 0; sl_auto = 0;
    repeat (3) step();
  endtask

  int seq[$];
  int done_cnt[N];
  int beats_left[N];
  int idle_wait[N];
  int gap, stalls, fired, acks, tos, waitc, a0, a1, dead;

  initial begin
    rst = 1; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat_w = '0;
    sl_ack = 0; sl_auto = 0; s_err = 0; s_dat_r = 32'h1234_5678;
    md_owner = -1; md_abort = 0; md_last = N - 1; md_stall = 0;
    cap_rst = 1; cap_cyc = '0; cap_stb = '0; cap_ack = 0; cap_err = 0; ex_fire = 0;
    edge_update();
    step();
    check_eq("rst_grant", ob_grant, N - 1);
    check_eq("rst_busy", ob_busy, 0);
    check_eq("rst_cyc", ob_cyc, 0);
    rst = 0;

    // single master write
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_adr[0] = 32'h100;
    m_dat_w[0] = 32'hDEAD_BEEF; m_sel[0] = 4'hF;
    step();
    check_eq("t1_idle_cyc", ob_cyc, 0);
    sl_ack = 1;
    step();
    check_eq("t1_cyc", ob_cyc, 1);
    check_eq("t1_adr", ob_adr, 32'h100);
    check_eq("t1_dat", ob_dat_w, 32'hDEAD_BEEF);
    check_eq("t1_ack", ob_ack, 2'b01);
    check_eq("t1_grant", ob_grant, 0);
    check_eq("t1_busy", ob_busy, 1);
    $display("txn t1 m0 write adr=100 dat=deadbeef ack=%0b", ob_ack[0]);
    m_cyc[0] = 0; m_stb[0] = 0; sl_ack = 0;
    step();
    check_eq("t1_rel_cyc", ob_cyc, 0);
    step();
    check_eq("t1_busy_end", ob_busy, 0);

    // contention: alternating single-beat cycles from both masters
    settle();
    rst = 1; step(); rst = 0;
    sl_auto = 1; done_cnt[0] = 0; done_cnt[1] = 0; gap = 0; seq.delete();
    for (int i = 0; i < N; i++) begin m_cyc[i] = 1; m_stb[i] = 1; new_beat(i); end
    for (int c = 0; c < 80 && (done_cnt[0] < 4 || done_cnt[1] < 4); c++) begin
      step();
      if (ob_cyc && ob_ack != 0) begin
        seq.push_back(ob_grant);
        if (seq.size() > 1) check_eq("t2_gap", gap, 2);
        gap = 0;
        if (ob_grant == 0) check_eq("t2_m1_ack", ob_ack[1], 0);
        $display("txn t2 m%0d beat acked", ob_grant);
      end else gap++;
      for (int i = 0; i < N; i++) begin
        if (m_cyc[i] && ob_ack[i]) begin
          done_cnt[i]++; m_cyc[i] = 0; m_stb[i] = 0;
        end else if (!m_cyc[i] && done_cnt[i] < 4) begin
          m_cyc[i] = 1; m_stb[i] = 1; new_beat(i);
        end
      end
    end
    check_eq("t2_count", seq.size(), 8);
    for (int i = 0; i < 8; i++) check_eq("t2_order", (i < seq.size()) ? seq[i] : -1, i % 2);

    // hold: master 1 keeps the bus for 3 beats while master 0 waits
    settle();
    sl_auto = 1; seq.delete(); a0 = 0; a1 = 0;
    m_cyc[1] = 1; m_stb[1] = 1; new_beat(1);
    step();
    m_cyc[0] = 1; m_stb[0] = 1; new_beat(0);
    for (int c = 0; c < 40 && a0 == 0; c++) begin
      step();
      if (ob_cyc && ob_ack != 0) seq.push_back(ob_grant);
      if (m_cyc[1] && ob_ack[1]) begin
        a1++;
        if (a1 == 3) begin m_cyc[1] = 0; m_stb[1] = 0; end else new_beat(1);
      end
      if (m_cyc[0] && ob_ack[0]) begin a0++; m_cyc[0] = 0; m_stb[0] = 0; end
    end
    $display("txn t3 m1 beats=%0d then m0 beats=%0d", a1, a0);
    check_eq("t3_count", seq.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("t3_order", (i < seq.size()) ? seq[i] : -1, (i < 3) ? 1 : 0);

    // watchdog fires on a silent slave
    settle();
    stalls = 0; fired = 0;
    m_cyc[0] = 1; m_stb[0] = 1; new_beat(0);
    for (int c = 0; c < 40 && fired == 0; c++) begin
      step();
      if (ob_to) fired = 1;
      else if (ob_cyc && ob_stb) stalls++;
    end
    check_eq("t4_fired", fired, 1);
    check_eq("t4_stalls", stalls, TO);
    check_eq("t4_cyc_at_to", ob_cyc, 0);
    check_eq("t4_err", ob_err, 2'b01);
    $display("txn t4 m0 aborted after %0d stalled cycles", stalls);
    sl_ack = 1;
    repeat (3) begin
      step();
      check_eq("t4_late_ack", ob_ack, 0);
      check_eq("t4_abort_busy", ob_busy, 1);
      check_eq("t4_abort_cyc", ob_cyc, 0);
    end
    m_cyc[0] = 0; m_stb[0] = 0; sl_ack = 0;
    step();
    step();
    check_eq("t4_idle", ob_busy, 0);

    // watchdog restarts on every ack: 7 stalls per beat never times out
    settle();
    acks = 0; tos = 0; waitc = 0;
    m_cyc[0] = 1; m_stb[0] = 1; new_beat(0);
    for (int c = 0; c < 60 && acks < 3; c++) begin
      step();
      if (ob_to) tos++;
      if (ob_ack[0]) begin
        acks++; sl_ack = 0; waitc = 0;
        if (acks == 3) begin m_cyc[0] = 0; m_stb[0] = 0; end else new_beat(0);
      end else if (ob_cyc && ob_stb) begin
        waitc++;
        if (waitc == TO - 1) sl_ack = 1;
      end
    end
    $display("txn t5 m0 beats=%0d timeouts=%0d", acks, tos);
    check_eq("t5_acks", acks, 3);
    check_eq("t5_timeouts", tos, 0);

    // reset in the middle of a granted cycle
    settle();
    m_cyc[0] = 1; m_stb[0] = 1; new_beat(0);
    step();
    step();
    check_eq("t6_pre_cyc", ob_cyc, 1);
    check_eq("t6_pre_grant", ob_grant, 0);
    rst = 1; sl_ack = 1;
    step();
    check_eq("t6_rst_ack", ob_ack, 0);
    rst = 0; sl_ack = 0;
    m_cyc[1] = 1; m_stb[1] = 1; new_beat(1);
    step();
    check_eq("t6_post_cyc", ob_cyc, 0);
    check_eq("t6_post_grant", ob_grant, N - 1);
    step();
    check_eq("t6_regrant_cyc", ob_cyc, 1);
    check_eq("t6_regrant", ob_grant, 0);
    $display("txn t6 reset mid-transfer, regrant to m%0d", ob_grant);

    // randomized traffic
    settle();
    dead = 0;
    for (int i = 0; i < N; i++) begin beats_left[i] = 0; idle_wait[i] = 0; end
    for (int c = 0; c < 2500; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (m_cyc[i]) begin
          if (ob_err[i]) begin
            $display("txn rnd m%0d err beats_left=%0d", i, beats_left[i]);
            m_cyc[i] = 0; m_stb[i] = 0; idle_wait[i] = $urandom_range(0, 3);
          end else if (ob_ack[i]) begin
            beats_left[i]--;
            if (beats_left[i] == 0) begin
              $display("txn rnd m%0d ok", i);
              m_cyc[i] = 0; m_stb[i] = 0; idle_wait[i] = $urandom_range(0, 3);
            end else new_beat(i);
          end
        end else if (idle_wait[i] > 0) idle_wait[i]--;
        else if ($urandom_range(0, 2) == 0) begin
          beats_left[i] = $urandom_range(1, 3);
          m_cyc[i] = 1; m_stb[i] = 1; new_beat(i);
        end
      end
      s_dat_r = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      if (dead > 0) begin
        dead--; sl_ack = 0; s_err = 0;
      end else begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 2) dead = 12;
        sl_ack = (r >= 2 && r < 40);
        s_err  = (r >= 40 && r < 45);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
